// File: rtl/bus_register_responder_if.sv
// Slave request/response bundle for one register-bank endpoint.
// Write and read channels are independent; each has a one-cycle request
// pulse in and done/busy/ready/error status out.
interface bus_register_responder_if;
  logic        write_request_i;
  logic [31:0] write_address_i;
  logic [31:0] write_data_i;
  logic [3:0]  write_strobe_i;
  logic        write_done_o;
  logic        write_error_o;
  logic        write_busy_o;
  logic        write_ready_o;

  logic        read_request_i;
  logic [31:0] read_address_i;
  logic [31:0] read_data_o;
  logic        read_done_o;
  logic        read_error_o;
  logic        read_busy_o;
  logic        read_ready_o;

  modport slave (
    input  write_request_i, write_address_i, write_data_i, write_strobe_i,
    output write_done_o, write_error_o, write_busy_o, write_ready_o,
    input  read_request_i, read_address_i,
    output read_data_o, read_done_o, read_error_o, read_busy_o, read_ready_o
  );

  modport master (
    output write_request_i, write_address_i, write_data_i, write_strobe_i,
    input  write_done_o, write_error_o, write_busy_o, write_ready_o,
    output read_request_i, read_address_i,
    input  read_data_o, read_done_o, read_error_o, read_busy_o, read_ready_o
  );
endinterface

// File: rtl/bus_register_responder.sv
// Memory-mapped register bank responder with independent write and read
// channels, each a small IDLE/WAIT/RESPOND FSM with a down-counting wait timer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready to accept a request (ready=1, busy=0)
// ST_WAIT    | wait-state timer counting down to 0 (busy=1)
// ST_RESPOND | one-cycle completion: done=1, error=latched decode error
module bus_register_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          DEPTH        = 16,
  parameter int          WAIT_CYCLES  = 0
) (
  input logic                      clk_i,
  input logic                      rst_n_i,
  bus_register_responder_if.slave  bus
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam bit          HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0]  CNT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESPOND} state_t;

  // Offset wraps unsigned, so addresses below the base land far out of range.
  function automatic logic decode_err(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDRESS;
    return (off >= SPAN) || (addr[1:0] != 2'b00);
  endfunction

  function automatic logic [AW-1:0] decode_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDRESS;
    return AW'(off >> 2);
  endfunction

  logic [31:0]   bank [DEPTH];

  state_t        wr_state;
  logic [3:0]    wr_cnt;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic          wr_err;
  logic          wr_ready, wr_busy, wr_done, wr_error;

  state_t        rd_state;
  logic [3:0]    rd_cnt;
  logic [AW-1:0] rd_idx;
  logic          rd_err;
  logic          rd_ready, rd_busy, rd_done, rd_error;
  logic [31:0]   rd_data;

  // Write channel FSM: capture request, count wait states, pulse done.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_state <= ST_IDLE;
      wr_cnt   <= 4'd0;
      wr_idx   <= '0;
      wr_data  <= 32'h0;
      wr_strb  <= 4'h0;
      wr_err   <= 1'b0;
      wr_ready <= 1'b1;
      wr_busy  <= 1'b0;
      wr_done  <= 1'b0;
      wr_error <= 1'b0;
    end else begin
      case (wr_state)
        ST_IDLE: begin
          if (bus.write_request_i) begin
            wr_idx   <= decode_idx(bus.write_address_i);
            wr_data  <= bus.write_data_i;
            wr_strb  <= bus.write_strobe_i;
            wr_err   <= decode_err(bus.write_address_i);
            wr_cnt   <= CNT_LOAD;
            wr_ready <= 1'b0;
            wr_busy  <= 1'b1;
            if (HAS_WAIT) begin
              wr_state <= ST_WAIT;
            end else begin
              wr_state <= ST_RESPOND;
              wr_done  <= 1'b1;
              wr_error <= decode_err(bus.write_address_i);
            end
          end
        end
        ST_WAIT: begin
          if (wr_cnt == 4'd0) begin
            wr_state <= ST_RESPOND;
            wr_done  <= 1'b1;
            wr_error <= wr_err;
          end else begin
            wr_cnt <= wr_cnt - 4'd1;
          end
        end
        default: begin
          wr_state <= ST_IDLE;
          wr_ready <= 1'b1;
          wr_busy  <= 1'b0;
          wr_done  <= 1'b0;
          wr_error <= 1'b0;
        end
      endcase
    end
  end

  // Register bank: byte-masked commit on the edge that ends write RESPOND.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= 32'h0;
      end
    end else if (wr_state == ST_RESPOND && !wr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          bank[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read channel FSM: data is loaded on the edge entering RESPOND, so a
  // coincident same-word commit is not yet visible (pre-write value returned).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_state <= ST_IDLE;
      rd_cnt   <= 4'd0;
      rd_idx   <= '0;
      rd_err   <= 1'b0;
      rd_ready <= 1'b1;
      rd_busy  <= 1'b0;
      rd_done  <= 1'b0;
      rd_error <= 1'b0;
      rd_data  <= 32'h0;
    end else begin
      case (rd_state)
        ST_IDLE: begin
          if (bus.read_request_i) begin
            rd_idx   <= decode_idx(bus.read_address_i);
            rd_err   <= decode_err(bus.read_address_i);
            rd_cnt   <= CNT_LOAD;
            rd_ready <= 1'b0;
            rd_busy  <= 1'b1;
            if (HAS_WAIT) begin
              rd_state <= ST_WAIT;
            end else begin
              rd_state <= ST_RESPOND;
              rd_done  <= 1'b1;
              rd_error <= decode_err(bus.read_address_i);
              rd_data  <= decode_err(bus.read_address_i) ? 32'h0
                                                          : bank[decode_idx(bus.read_address_i)];
            end
          end
        end
        ST_WAIT: begin
          if (rd_cnt == 4'd0) begin
            rd_state <= ST_RESPOND;
            rd_done  <= 1'b1;
            rd_error <= rd_err;
            rd_data  <= rd_err ? 32'h0 : bank[rd_idx];
          end else begin
            rd_cnt <= rd_cnt - 4'd1;
          end
        end
        default: begin
          rd_state <= ST_IDLE;
          rd_ready <= 1'b1;
          rd_busy  <= 1'b0;
          rd_done  <= 1'b0;
          rd_error <= 1'b0;
        end
      endcase
    end
  end

  assign bus.write_ready_o = wr_ready;
  assign bus.write_busy_o  = wr_busy;
  assign bus.write_done_o  = wr_done;
  assign bus.write_error_o = wr_error;

  assign bus.read_ready_o  = rd_ready;
  assign bus.read_busy_o   = rd_busy;
  assign bus.read_done_o   = rd_done;
  assign bus.read_error_o  = rd_error;
  assign bus.read_data_o   = rd_data;

endmodule

// File: tb/tb_bus_register_responder.sv
// Directed bench: dut_a has two wait states, dut_b has none; both share
// BASE=0x1000, DEPTH=16 and one clock/reset.
module tb_bus_register_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bus_register_responder_if if_a ();
  bus_register_responder_if if_b ();

  bus_register_responder #(.BASE_ADDRESS(32'h1000), .DEPTH(16), .WAIT_CYCLES(2)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if_a.slave));
  bus_register_responder #(.BASE_ADDRESS(32'h1000), .DEPTH(16), .WAIT_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if_b.slave));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic drive_wr(input bit sel, input logic req, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    if (sel) begin
      if_b.write_request_i = req; if_b.write_address_i = addr;
      if_b.write_data_i = data;   if_b.write_strobe_i = strb;
    end else begin
      if_a.write_request_i = req; if_a.write_address_i = addr;
      if_a.write_data_i = data;   if_a.write_strobe_i = strb;
    end
  endtask

  task automatic drive_rd(input bit sel, input logic req, input logic [31:0] addr);
    if (sel) begin
      if_b.read_request_i = req; if_b.read_address_i = addr;
    end else begin
      if_a.read_request_i = req; if_a.read_address_i = addr;
    end
  endtask

  // lat = cycles after acceptance until done (1 = T+1); 0 means no done seen.
  task automatic do_write(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic err, output int lat);
    @(negedge clk); drive_wr(sel, 1'b1, addr, data, strb);
    @(negedge clk); drive_wr(sel, 1'b0, 32'h0, 32'h0, 4'h0);
    lat = 0; err = 1'bx;
    for (int i = 1; i <= 12; i++) begin
      if (sel ? if_b.write_done_o : if_a.write_done_o) begin
        lat = i; err = sel ? if_b.write_error_o : if_a.write_error_o;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_read(input bit sel, input logic [31:0] addr, output logic [31:0] data,
                         output logic err, output int lat);
    @(negedge clk); drive_rd(sel, 1'b1, addr);
    @(negedge clk); drive_rd(sel, 1'b0, 32'h0);
    lat = 0; err = 1'bx; data = 32'hx;
    for (int i = 1; i <= 12; i++) begin
      if (sel ? if_b.read_done_o : if_a.read_done_o) begin
        lat = i; err = sel ? if_b.read_error_o : if_a.read_error_o;
        data = sel ? if_b.read_data_o : if_a.read_data_o;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e; int lat;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({if_a.write_ready_o, if_a.write_busy_o, if_a.write_done_o, if_a.write_error_o} !== 4'b1000) begin
      errors++; $display("FAIL rst_a_wr_status: got %b want 1000", {if_a.write_ready_o, if_a.write_busy_o, if_a.write_done_o, if_a.write_error_o}); end
    checks++; if ({if_a.read_ready_o, if_a.read_busy_o, if_a.read_done_o, if_a.read_error_o} !== 4'b1000) begin
      errors++; $display("FAIL rst_a_rd_status: got %b want 1000", {if_a.read_ready_o, if_a.read_busy_o, if_a.read_done_o, if_a.read_error_o}); end
    checks++; if ({if_b.write_ready_o, if_b.write_busy_o, if_b.write_done_o, if_b.write_error_o} !== 4'b1000) begin
      errors++; $display("FAIL rst_b_wr_status: got %b want 1000", {if_b.write_ready_o, if_b.write_busy_o, if_b.write_done_o, if_b.write_error_o}); end
    checks++; if ({if_b.read_ready_o, if_b.read_busy_o, if_b.read_done_o, if_b.read_error_o} !== 4'b1000) begin
      errors++; $display("FAIL rst_b_rd_status: got %b want 1000", {if_b.read_ready_o, if_b.read_busy_o, if_b.read_done_o, if_b.read_error_o}); end
    checks++; if (if_a.read_data_o !== 32'h0) begin
      errors++; $display("FAIL rst_a_rdata: got %h want 00000000", if_a.read_data_o); end
    @(negedge clk); rst_n = 1'b1;
    do_read(1'b0, 32'h1004, d, e, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL idle_read_latency: got %0d want 3", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL idle_read_err: got %b want 0", e); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL idle_read_data: got %h want 00000000", d); end
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic e; int lat;
    logic [3:0] exp_st [4];
    logic [3:0] got;
    exp_st = '{4'b0100, 4'b0100, 4'b0110, 4'b1000};
    @(negedge clk); drive_wr(1'b0, 1'b1, 32'h1008, 32'hDEADBEEF, 4'hF);
    @(negedge clk); drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      got = {if_a.write_ready_o, if_a.write_busy_o, if_a.write_done_o, if_a.write_error_o};
      checks++; if (got !== exp_st[k]) begin
        errors++; $display("FAIL wr_timing_T+%0d: got %b want %b", k + 1, got, exp_st[k]); end
      @(negedge clk);
    end
    do_read(1'b0, 32'h1008, d, e, lat);
    checks++; if (d !== 32'hDEADBEEF || e !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL readback_full: got %h err %b lat %0d want deadbeef err 0 lat 3", d, e, lat); end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic e; int lat;
    do_write(1'b0, 32'h1008, 32'h11223344, 4'b0101, e, lat);
    checks++; if (e !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL strobe_write_done: got err %b lat %0d want err 0 lat 3", e, lat); end
    do_read(1'b0, 32'h1008, d, e, lat);
    checks++; if (d !== 32'hDE22BE44) begin errors++; $display("FAIL strobe_merge: got %h want de22be44", d); end
    do_write(1'b0, 32'h1008, 32'hFFFFFFFF, 4'b0000, e, lat);
    checks++; if (e !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL strobe0_done: got err %b lat %0d want err 0 lat 3", e, lat); end
    do_read(1'b0, 32'h1008, d, e, lat);
    checks++; if (d !== 32'hDE22BE44) begin errors++; $display("FAIL strobe0_unchanged: got %h want de22be44", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int lat;
    do_read(1'b0, 32'h1040, d, e, lat);
    checks++; if (e !== 1'b1 || d !== 32'h0 || lat !== 3) begin
      errors++; $display("FAIL rd_past_end: got err %b data %h lat %0d want err 1 data 0 lat 3", e, d, lat); end
    do_read(1'b0, 32'h103C, d, e, lat);
    checks++; if (e !== 1'b0 || d !== 32'h0) begin
      errors++; $display("FAIL rd_last_word: got err %b data %h want err 0 data 0", e, d); end
    do_write(1'b0, 32'h0FFC, 32'hCAFEF00D, 4'hF, e, lat);
    checks++; if (e !== 1'b1 || lat !== 3) begin
      errors++; $display("FAIL wr_below_base: got err %b lat %0d want err 1 lat 3", e, lat); end
    do_write(1'b0, 32'h1002, 32'hCAFEF00D, 4'hF, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL wr_misaligned: got err %b want 1", e); end
    do_read(1'b0, 32'h103C, d, e, lat);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL below_base_no_write: got %h want 00000000", d); end
    do_read(1'b0, 32'h1000, d, e, lat);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL misaligned_no_write: got %h want 00000000", d); end
    do_read(1'b0, 32'h1008, d, e, lat);
    checks++; if (d !== 32'hDE22BE44) begin errors++; $display("FAIL err_bank_intact: got %h want de22be44", d); end
  endtask

  task automatic test_busy_reset();
    logic [31:0] d; logic e; int lat; int n;
    @(negedge clk); drive_wr(1'b0, 1'b1, 32'h1010, 32'hA5A5A5A5, 4'hF);
    @(negedge clk); drive_wr(1'b0, 1'b1, 32'h1010, 32'h12345678, 4'hF);
    @(negedge clk); drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (if_a.write_done_o) n++;
      @(negedge clk);
    end
    checks++; if (n !== 1) begin errors++; $display("FAIL busy_ignored_done_count: got %0d want 1", n); end
    do_read(1'b0, 32'h1010, d, e, lat);
    checks++; if (d !== 32'hA5A5A5A5) begin errors++; $display("FAIL busy_first_data: got %h want a5a5a5a5", d); end
    @(negedge clk); drive_wr(1'b0, 1'b1, 32'h1014, 32'h00000077, 4'hF);
    @(negedge clk); drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; if ({if_a.write_ready_o, if_a.write_busy_o, if_a.write_done_o} !== 3'b100) begin
      errors++; $display("FAIL midwrite_rst_status: got %b want 100", {if_a.write_ready_o, if_a.write_busy_o, if_a.write_done_o}); end
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (if_a.write_done_o) n++;
      @(negedge clk);
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL midwrite_rst_no_done: got %0d want 0", n); end
    do_read(1'b0, 32'h1014, d, e, lat);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midwrite_rst_dropped: got %h want 00000000", d); end
    do_read(1'b0, 32'h1010, d, e, lat);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_clears_bank: got %h want 00000000", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int lat;
    logic [3:0] got;
    @(negedge clk); drive_wr(1'b1, 1'b1, 32'h1000, 32'h5, 4'hF);
    @(negedge clk); drive_wr(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    got = {if_b.write_ready_o, if_b.write_busy_o, if_b.write_done_o, if_b.write_error_o};
    checks++; if (got !== 4'b0110) begin errors++; $display("FAIL b2b_first_done_T+1: got %b want 0110", got); end
    @(negedge clk);
    got = {if_b.write_ready_o, if_b.write_busy_o, if_b.write_done_o, if_b.write_error_o};
    checks++; if (got !== 4'b1000) begin errors++; $display("FAIL b2b_ready_T+2: got %b want 1000", got); end
    drive_wr(1'b1, 1'b1, 32'h1004, 32'h6, 4'hF);
    @(negedge clk); drive_wr(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    got = {if_b.write_ready_o, if_b.write_busy_o, if_b.write_done_o, if_b.write_error_o};
    checks++; if (got !== 4'b0110) begin errors++; $display("FAIL b2b_second_done_T+3: got %b want 0110", got); end
    @(negedge clk);
    drive_wr(1'b1, 1'b1, 32'h1000, 32'h9, 4'hF);
    drive_rd(1'b1, 1'b1, 32'h1000);
    @(negedge clk);
    drive_wr(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_rd(1'b1, 1'b0, 32'h0);
    checks++; if ({if_b.read_done_o, if_b.write_done_o} !== 2'b11) begin
      errors++; $display("FAIL collide_both_done: got %b want 11", {if_b.read_done_o, if_b.write_done_o}); end
    checks++; if (if_b.read_data_o !== 32'h5) begin
      errors++; $display("FAIL collide_old_value: got %h want 00000005", if_b.read_data_o); end
    do_read(1'b1, 32'h1000, d, e, lat);
    checks++; if (d !== 32'h9 || lat !== 1) begin
      errors++; $display("FAIL collide_new_value: got %h lat %0d want 00000009 lat 1", d, lat); end
    do_read(1'b1, 32'h1004, d, e, lat);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL b2b_second_data: got %h want 00000006", d); end
    do_read(1'b1, 32'h2000, d, e, lat);
    checks++; if (e !== 1'b1 || d !== 32'h0 || lat !== 1) begin
      errors++; $display("FAIL b_err_read: got err %b data %h lat %0d want err 1 data 0 lat 1", e, d, lat); end
  endtask

  initial begin
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_rd(1'b0, 1'b0, 32'h0);
    drive_wr(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_rd(1'b1, 1'b0, 32'h0);
    test_reset();
    test_write_read();
    test_strobe();
    test_errors();
    test_busy_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
